grid_scan_tx: RTL and testbench

Reader/transmitter for the 49-bit Game of Life grid produced by the datapath. It snapshots the grid once per frame and row-scans it to an external 7x7 LED matrix through a serial shift-register chain (74HC595-style: sclk, sdata, slatch, oe_n). It sits between the datapath grid output and the board display pins.

---
 rtl/gol_pkg.sv | 13 +
 rtl/row_serializer.sv | 62 ++++++
 rtl/grid_scan_tx.sv | 135 +++++++++++++
 tb/tb_grid_scan_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and geometry for the Game of Life display path.
package gol_pkg;
  localparam int unsigned GRID_ROWS  = 7;
  localparam int unsigned GRID_COLS  = 7;
  localparam int unsigned GRID_CELLS = 49;
  localparam int unsigned ROW_WORD_W = 14;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} scan_state_t;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return r * GRID_COLS + c;
  endfunction
endpackage

// File: rtl/row_serializer.sv
// PISO shifter for one row word: MSB first, sclk rises mid-bit, done on the last cycle of the last bit.
module row_serializer
  import gol_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned WORD_W  = ROW_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              sdata,
  output logic              sclk,
  output logic              done
);
  localparam int unsigned PH_MAX = 2 * CLK_DIV - 1;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);
  localparam int unsigned BW     = $clog2(WORD_W);
  localparam logic [PW-1:0] PH_LAST  = PW'(PH_MAX);
  localparam logic [PW-1:0] PH_HIGH  = PW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  logic [WORD_W-1:0] shreg;
  logic [PW-1:0]     phase;
  logic [BW-1:0]     bit_cnt;
  logic              busy;
  logic              ph_end;

  assign ph_end = (phase == PH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      if (load) begin
        shreg   <= word;
        phase   <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        if (ph_end) begin
          phase   <= '0;
          shreg   <= {shreg[WORD_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BW'(1);
        end else begin
          phase <= phase + PW'(1);
        end
      end
      if (start)
        busy <= 1'b1;
      else if (busy && ph_end && (bit_cnt == BIT_LAST))
        busy <= 1'b0;
    end
  end

  assign sdata = busy & shreg[WORD_W-1];
  assign sclk  = busy & (phase >= PH_HIGH);
  assign done  = busy & ph_end & (bit_cnt == BIT_LAST);
endmodule

// File: rtl/grid_scan_tx.sv
// Snapshots the 7x7 life grid once per frame and row-scans it into a 74HC595-style LED chain.
module grid_scan_tx
  import gol_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GRID_ROWS   = 7,
  parameter int unsigned GRID_COLS   = 7
) (
  input  logic                           clka,
  input  logic                           rst,
  input  logic                           en,
  input  logic [GRID_ROWS*GRID_COLS-1:0] grid,
  output logic                           sclk,
  output logic                           sdata,
  output logic                           slatch,
  output logic                           oe_n,
  output logic [2:0]                     row_idx,
  output logic                           frame_done
);
  localparam int unsigned CELLS   = GRID_ROWS * GRID_COLS;
  localparam int unsigned CIW     = $clog2(CELLS);
  localparam int unsigned WORD_W  = GRID_ROWS + GRID_COLS;
  localparam int unsigned CNT_MAX = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LAT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    ROW_LAST  = 3'(GRID_ROWS - 1);

  scan_state_t       state, state_n;
  logic [2:0]        row_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [CELLS-1:0]  snap, snap_n, src;
  logic [GRID_COLS-1:0] col_bits;
  logic [GRID_ROWS-1:0] row_onehot;
  logic [WORD_W-1:0] row_word;
  logic              ser_load, ser_start, ser_done;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_idx <= '0;
      cnt     <= '0;
      snap    <= '0;
    end else begin
      state   <= state_n;
      row_idx <= row_n;
      cnt     <= cnt_n;
      snap    <= snap_n;
    end
  end

  // Row 0 reads the live grid directly so its word matches the snapshot taken in the same cycle.
  always_comb begin
    src        = (row_idx == '0) ? grid : snap;
    col_bits   = '0;
    for (int unsigned c = 0; c < GRID_COLS; c++)
      col_bits[c] = src[CIW'(idx(32'(row_idx), c))];
    row_onehot = GRID_ROWS'(1) << row_idx;
    row_word   = {row_onehot, col_bits};
  end

  always_comb begin
    state_n    = state;
    row_n      = row_idx;
    cnt_n      = cnt;
    snap_n     = snap;
    ser_load   = 1'b0;
    ser_start  = 1'b0;
    slatch     = 1'b0;
    oe_n       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        row_n = '0;
        if (en) state_n = LOAD;
      end
      LOAD: begin
        if (row_idx == '0) snap_n = grid;
        ser_load  = 1'b1;
        ser_start = 1'b1;
        state_n   = SHIFT;
      end
      SHIFT: begin
        if (ser_done) begin
          cnt_n   = '0;
          state_n = LATCH;
        end
      end
      LATCH: begin
        slatch = 1'b1;
        if (cnt == LAT_LAST) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        oe_n = 1'b0;
        if (cnt == HOLD_LAST) begin
          cnt_n = '0;
          if (row_idx == ROW_LAST) begin
            frame_done = 1'b1;
            row_n      = '0;
            state_n    = en ? LOAD : IDLE;
          end else if (en) begin
            row_n   = row_idx + 3'd1;
            state_n = LOAD;
          end else begin
            row_n   = '0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  row_serializer #(
    .CLK_DIV (CLK_DIV),
    .WORD_W  (WORD_W)
  ) u_ser (
    .clk   (clka),
    .rst   (rst),
    .load  (ser_load),
    .start (ser_start),
    .word  (row_word),
    .sdata (sdata),
    .sclk  (sclk),
    .done  (ser_done)
  );
endmodule

// File: tb/tb_grid_scan_tx.sv
// Directed bench for grid_scan_tx: default timing instance plus a CLK_DIV=1/HOLD_CYCLES=1 instance.
module tb_grid_scan_tx;
  logic        clk;
  logic        rst;
  logic        en, en2;
  logic [48:0] grid, grid2;
  logic        sclk, sdata, slatch, oe_n, frame_done;
  logic [2:0]  row_idx;
  logic        sclk2, sdata2, slatch2, oe_n2, frame_done2;
  logic [2:0]  row_idx2;

  int checks = 0;
  int errors = 0;

  logic       a_sclk[0:999], a_sdata[0:999], a_slatch[0:999], a_oe[0:999], a_fd[0:999];
  logic [2:0] a_row[0:999];
  logic       b_sclk[0:999], b_sdata[0:999], b_slatch[0:999], b_oe[0:999], b_fd[0:999];
  logic [2:0] b_row[0:999];

  grid_scan_tx dut (
    .clka(clk), .rst(rst), .en(en), .grid(grid),
    .sclk(sclk), .sdata(sdata), .slatch(slatch), .oe_n(oe_n),
    .row_idx(row_idx), .frame_done(frame_done)
  );

  grid_scan_tx #(.CLK_DIV(1), .HOLD_CYCLES(1)) dut2 (
    .clka(clk), .rst(rst), .en(en2), .grid(grid2),
    .sclk(sclk2), .sdata(sdata2), .slatch(slatch2), .oe_n(oe_n2),
    .row_idx(row_idx2), .frame_done(frame_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sample k holds outputs just after the k-th edge following enable assertion.
  task automatic record(input int n, input bit use2, input int drop_at,
                        input int chg_at, input logic [48:0] g_new);
    if (use2) en2 = 1'b1; else en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      a_sclk[k] = sclk;  a_sdata[k] = sdata;  a_slatch[k] = slatch;
      a_oe[k] = oe_n;    a_fd[k] = frame_done; a_row[k] = row_idx;
      b_sclk[k] = sclk2; b_sdata[k] = sdata2; b_slatch[k] = slatch2;
      b_oe[k] = oe_n2;   b_fd[k] = frame_done2; b_row[k] = row_idx2;
      if (k == drop_at) begin en = 1'b0; en2 = 1'b0; end
      if (k == chg_at) grid = g_new;
    end
  endtask

  function automatic logic get(input bit d2, input int sig, input int k);
    case (sig)
      0: return d2 ? b_sclk[k]   : a_sclk[k];
      1: return d2 ? b_sdata[k]  : a_sdata[k];
      2: return d2 ? b_slatch[k] : a_slatch[k];
      3: return d2 ? !b_oe[k]    : !a_oe[k];
      default: return d2 ? b_fd[k] : a_fd[k];
    endcase
  endfunction

  function automatic int count(input bit d2, input int sig, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (get(d2, sig, k) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first(input bit d2, input int sig, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (get(d2, sig, k) === 1'b1) return k;
    return -1;
  endfunction

  // base is the LOAD sample of the row; each bit is read at its first sclk-high cycle.
  function automatic logic [13:0] word_of(input bit d2, input int base);
    logic [13:0] w = '0;
    int cd = d2 ? 1 : 2;
    for (int b = 0; b < 14; b++) w = {w[12:0], get(d2, 1, base + 1 + 2*cd*b + cd)};
    return w;
  endfunction

  initial begin
    logic [6:0]  oh;
    logic [6:0]  col;
    logic [48:0] g;

    rst = 1'b1; en = 1'b0; en2 = 1'b0; grid = '0; grid2 = '0;
    @(posedge clk); #1;
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_sdata", sdata, 1'b0);
    chk("rst_slatch", slatch, 1'b0);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_row", row_idx, 3'd0);
    chk("rst_fd", frame_done, 1'b0);
    do_reset();

    // Empty grid, full frame with default timing
    record(470, 1'b0, 0, 0, '0);
    chk("t1_word0", word_of(1'b0, 1), 14'b0000001_0000000);
    chk("t1_load_sclk", a_sclk[1], 1'b0);
    chk("t1_sclk_cnt", count(1'b0, 0, 1, 67), 28);
    chk("t1_latch_first", first(1'b0, 2, 1, 67), 58);
    chk("t1_latch_cnt", count(1'b0, 2, 1, 67), 2);
    chk("t1_oe_first", first(1'b0, 3, 1, 67), 60);
    chk("t1_oe_cnt", count(1'b0, 3, 1, 67), 8);
    chk("t1_row67", a_row[67], 3'd0);
    chk("t1_row68", a_row[68], 3'd1);
    chk("t1_fd_cnt", count(1'b0, 4, 1, 470), 1);
    chk("t1_fd_at", first(1'b0, 4, 1, 470), 469);
    chk("t1_row470", a_row[470], 3'd0);

    // Corner cells 0 and 48
    do_reset();
    g = '0; g[0] = 1'b1; g[48] = 1'b1; grid = g;
    record(470, 1'b0, 0, 0, '0);
    for (int r = 0; r < 7; r++) begin
      oh  = 7'b1 << r;
      col = (r == 0) ? 7'b0000001 : (r == 6) ? 7'b1000000 : 7'b0000000;
      chk($sformatf("t2_word_r%0d", r), word_of(1'b0, 1 + 67*r), {oh, col});
    end

    // Snapshot coherence across a mid-frame grid change
    do_reset();
    grid = '1;
    record(940, 1'b0, 0, 100, '0);
    for (int r = 1; r < 7; r++) begin
      oh = 7'b1 << r;
      chk($sformatf("t3_f1_r%0d", r), word_of(1'b0, 1 + 67*r), {oh, 7'b1111111});
    end
    chk("t3_f2_r0", word_of(1'b0, 470), {7'b0000001, 7'b0000000});
    chk("t3_f2_r3", word_of(1'b0, 470 + 201), {7'b0001000, 7'b0000000});

    // Enable dropped during row 3 shift
    do_reset();
    grid = '0;
    record(300, 1'b0, 210, 0, '0);
    chk("t4_r3_word", word_of(1'b0, 202), {7'b0001000, 7'b0000000});
    chk("t4_latch_cnt", count(1'b0, 2, 202, 300), 2);
    chk("t4_oe_first", first(1'b0, 3, 202, 300), 261);
    chk("t4_oe_cnt", count(1'b0, 3, 202, 300), 8);
    chk("t4_row268", a_row[268], 3'd3);
    chk("t4_row269", a_row[269], 3'd0);
    chk("t4_oe269", a_oe[269], 1'b1);
    chk("t4_sclk_idle", count(1'b0, 0, 269, 300), 0);
    chk("t4_no_fd", count(1'b0, 4, 1, 300), 0);
    record(70, 1'b0, 0, 0, '0);
    chk("t4_restart_row1", a_row[1], 3'd0);
    chk("t4_restart_word", word_of(1'b0, 1), 14'b0000001_0000000);
    chk("t4_restart_row68", a_row[68], 3'd1);

    // Asynchronous reset while sclk is high
    do_reset();
    grid = '0;
    en = 1'b1;
    for (int k = 1; k <= 28; k++) begin @(posedge clk); #1; end
    chk("t5_pre_sclk", sclk, 1'b1);
    chk("t5_pre_sdata", sdata, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_sclk", sclk, 1'b0);
    chk("t5_async_sdata", sdata, 1'b0);
    chk("t5_async_oe", oe_n, 1'b1);
    chk("t5_async_slatch", slatch, 1'b0);
    chk("t5_async_row", row_idx, 3'd0);
    do_reset();
    record(70, 1'b0, 0, 0, '0);
    chk("t5_restart_word", word_of(1'b0, 1), 14'b0000001_0000000);
    chk("t5_restart_row68", a_row[68], 3'd1);

    // Fastest timing instance
    do_reset();
    grid2 = '0;
    record(440, 1'b1, 0, 0, '0);
    chk("t6_word0", word_of(1'b1, 1), 14'b0000001_0000000);
    chk("t6_sclk_cnt", count(1'b1, 0, 1, 31), 14);
    chk("t6_latch_first", first(1'b1, 2, 1, 31), 30);
    chk("t6_latch_cnt", count(1'b1, 2, 1, 31), 1);
    chk("t6_oe_first", first(1'b1, 3, 1, 31), 31);
    chk("t6_oe_cnt", count(1'b1, 3, 1, 31), 1);
    chk("t6_row31", b_row[31], 3'd0);
    chk("t6_row32", b_row[32], 3'd1);
    chk("t6_fd_cnt", count(1'b1, 4, 1, 440), 2);
    chk("t6_fd_first", first(1'b1, 4, 1, 440), 217);
    chk("t6_fd_second", first(1'b1, 4, 218, 440), 434);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
